// File: rtl/param_sram_bytemask.sv
// param_sram_bytemask: parametrised byte-masked SRAM model with read pipeline, bypass and clear engine
module param_sram_bytemask #(
  parameter int BW         = 8,
  parameter int Q          = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_SPACE = 4,
  parameter int RD_LAT     = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wsb,
  input  logic [BW*Q-1:0]       wdata,
  input  logic [Q-1:0]          bytemask,
  input  logic [ADDR_SPACE-1:0] waddr,
  input  logic                  rsb,
  input  logic [ADDR_SPACE-1:0] raddr,
  input  logic                  clr_start,
  output logic [BW*Q-1:0]       rdata,
  output logic                  rvalid,
  output logic                  busy
);
  localparam int W = BW * Q;
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] IDLE  = 1'b1;
  localparam logic [ADDR_SPACE:0]   DEP  = (ADDR_SPACE + 1)'(DEPTH);
  localparam logic [ADDR_SPACE-1:0] LAST = ADDR_SPACE'(DEPTH - 1);
  logic [W-1:0] mem [DEPTH];
  logic [0:0] state;
  logic [ADDR_SPACE-1:0] cnt;
  logic idle, in_w, in_r, wr_en, rd_en, v1;
  logic [W-1:0] merged, rd_val, d1;
  assign idle  = state == IDLE;
  assign busy  = !idle;
  assign in_w  = {1'b0, waddr} < DEP;
  assign in_r  = {1'b0, raddr} < DEP;
  // clr_start in the same cycle as a write wins; the write is dropped
  assign wr_en = idle && !wsb && !clr_start && in_w;
  assign rd_en = idle && !rsb;
  for (genvar g = 0; g < Q; g++) begin : g_lane
    assign merged[g*BW +: BW] = bytemask[g] ? mem[waddr][g*BW +: BW] : wdata[g*BW +: BW];
  end
  assign rd_val = !in_r ? '0 : (BYPASS != 0 && wr_en && raddr == waddr) ? merged : mem[raddr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else if (!idle) begin
      cnt <= cnt + 1'b1;
      if (cnt == LAST) state <= IDLE;
    end else if (clr_start) begin
      state <= CLEAR;
      cnt   <= '0;
    end
  end
  // array has no reset; the clear engine zeroes it instead
  always_ff @(posedge clk) begin
    if (!idle) mem[cnt] <= '0;
    else if (wr_en) mem[waddr] <= merged;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else begin
      v1 <= rd_en;
      if (rd_en) d1 <= rd_val;
    end
  end
  if (RD_LAT == 2) begin : g_lat2
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rvalid <= 1'b0;
        rdata  <= '0;
      end else begin
        rvalid <= v1;
        if (v1) rdata <= d1;
      end
    end
  end else begin : g_lat1
    assign rvalid = v1;
    assign rdata  = d1;
  end
  // bench preload; only meaningful while busy is low
  task automatic load_param(input int index, input logic [W-1:0] data);
    mem[index] <= data;
  endtask
endmodule

// File: tb/tb_param_sram_bytemask.sv
// tb_param_sram_bytemask: random + directed bench for two SRAM configurations against a behavioural model
module tb_param_sram_bytemask;
  logic clk = 1'b0, rst_n = 1'b0, wsb = 1'b1, rsb = 1'b1, clr_start = 1'b0;
  logic [3:0] waddr = '0, raddr = '0;
  logic [127:0] wdata = '0;
  logic [15:0] bytemask = '0;
  logic [127:0] rdata0, rdata1;
  logic rvalid0, rvalid1, busy0, busy1;
  int errors = 0, checks = 0, cyc = 0;
  int dep [2] = '{16, 12};
  int lat [2] = '{1, 2};
  int byp [2] = '{1, 0};
  logic [127:0] m [2][16];
  logic [127:0] sd [2][8];
  bit sv [2][8];
  logic [127:0] ed [2];
  bit ev [2];
  int left [2];
  always #5 clk = ~clk;

  param_sram_bytemask u0 (.clk(clk), .rst_n(rst_n), .wsb(wsb), .wdata(wdata), .bytemask(bytemask),
    .waddr(waddr), .rsb(rsb), .raddr(raddr), .clr_start(clr_start), .rdata(rdata0), .rvalid(rvalid0), .busy(busy0));
  param_sram_bytemask #(.DEPTH(12), .RD_LAT(2), .BYPASS(0)) u1 (.clk(clk), .rst_n(rst_n), .wsb(wsb), .wdata(wdata),
    .bytemask(bytemask), .waddr(waddr), .rsb(rsb), .raddr(raddr), .clr_start(clr_start), .rdata(rdata1),
    .rvalid(rvalid1), .busy(busy1));

  function automatic logic [127:0] mrg(input logic [127:0] o, input logic [127:0] n, input logic [15:0] bm);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = bm[i] ? o[i*8 +: 8] : n[i*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input int k);
    logic [127:0] val;
    bit we;
    int d = dep[k];
    if (!rst_n) begin
      left[k] = d;
      for (int s = 0; s < 8; s++) sv[k][s] = 0;
      ev[k] = 0;
      ed[k] = '0;
      return;
    end
    we = left[k] == 0 && !clr_start && !wsb && int'(waddr) < d;
    if (left[k] == 0 && !rsb) begin
      val = int'(raddr) >= d ? '0 :
            (byp[k] == 1 && we && raddr == waddr) ? mrg(m[k][waddr], wdata, bytemask) : m[k][raddr];
      sv[k][(cyc + lat[k] - 1) % 8] = 1;
      sd[k][(cyc + lat[k] - 1) % 8] = val;
    end
    ev[k] = sv[k][cyc % 8];
    if (ev[k]) ed[k] = sd[k][cyc % 8];
    sv[k][cyc % 8] = 0;
    if (left[k] > 0) begin
      m[k][d - left[k]] = '0;
      left[k]--;
    end else if (clr_start) left[k] = d;
    else if (we) m[k][waddr] = mrg(m[k][waddr], wdata, bytemask);
  endtask

  always @(posedge clk) begin
    cyc++;
    step(0);
    step(1);
    #1;
    chk("rdata0", rdata0, ed[0]);
    chk("rvalid0", rvalid0, ev[0]);
    chk("busy0", busy0, left[0] != 0);
    chk("rdata1", rdata1, ed[1]);
    chk("rvalid1", rvalid1, ev[1]);
    chk("busy1", busy1, left[1] != 0);
  end

  task automatic drv(input bit w, input int wa, input logic [127:0] wd, input logic [15:0] bm,
                     input bit r, input int ra, input bit c);
    wsb = !w; waddr = wa[3:0]; wdata = wd; bytemask = bm;
    rsb = !r; raddr = ra[3:0]; clr_start = c;
    @(negedge clk);
  endtask

  task automatic idle();
    drv(0, 0, '0, '0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n0, n1;
    bit seen;
    logic [127:0] p, e3;
    p  = 128'h0F0E0D0C0B0A09080706050403020100;
    e3 = 128'h0F0E0D0C0B0A0908FFFFFFFFFFFFFFFF;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 30; i++) begin
      n0 += int'(busy0); n1 += int'(busy1);
      @(negedge clk);
    end
    chk("reset_busy_len0", n0, 16);
    chk("reset_busy_len1", n1, 12);
    for (int a = 0; a < 16; a++) drv(0, 0, '0, '0, 1, a, 0);
    repeat (3) idle();
    drv(1, 3, p, 16'h0000, 0, 0, 0);
    drv(1, 3, '1, 16'hFF00, 0, 0, 0);
    drv(0, 0, '0, '0, 1, 3, 0);
    chk("mask_rd0", rdata0, e3);
    chk("mask_rv0", rvalid0, 1);
    idle();
    chk("mask_rd1", rdata1, e3);
    chk("mask_rv0_strobe", rvalid0, 0);
    drv(1, 5, {16{8'hAA}}, 16'h0, 0, 0, 0);
    drv(1, 5, {16{8'h55}}, 16'h0, 1, 5, 0);
    chk("bypass_new0", rdata0, {16{8'h55}});
    idle();
    chk("nobypass_old1", rdata1, {16{8'hAA}});
    drv(0, 0, '0, '0, 1, 5, 0);
    idle();
    chk("reread0", rdata0, {16{8'h55}});
    chk("reread1", rdata1, {16{8'h55}});
    for (int a = 0; a < 3; a++) drv(1, a, {16{8'h11}} * (a + 1), 16'h0, 0, 0, 0);
    drv(0, 0, '0, '0, 1, 0, 0);
    chk("lat2_not_yet", rvalid1, 0);
    drv(0, 0, '0, '0, 1, 1, 0);
    drv(0, 0, '0, '0, 1, 2, 0);
    repeat (3) idle();
    chk("lat2_hold", rdata1, {16{8'h33}});
    chk("lat2_idle_rv", rvalid1, 0);
    drv(1, 7, {16{8'h77}}, 16'h0, 0, 0, 0);
    drv(1, 7, {16{8'hEE}}, 16'h0, 0, 0, 1);
    n0 = 0; n1 = 0; seen = 0;
    for (int i = 0; i < 30; i++) begin
      n0 += int'(busy0); n1 += int'(busy1);
      seen |= rvalid0 | rvalid1;
      drv(0, 0, '0, '0, i == 2, 1, i == 3);
    end
    chk("clear_len0", n0, 16);
    chk("clear_len1", n1, 12);
    chk("busy_read_dropped", seen, 0);
    drv(0, 0, '0, '0, 1, 7, 0);
    chk("cleared7", rdata0, '0);
    chk("cleared7_rv", rvalid0, 1);
    drv(1, 13, {16{8'hC3}}, 16'h0, 0, 0, 0);
    drv(0, 0, '0, '0, 1, 13, 0);
    chk("oor_inrange0", rdata0, {16{8'hC3}});
    idle();
    chk("oor_rd1", rdata1, '0);
    chk("oor_rv1", rvalid1, 1);
    for (int a = 0; a < 16; a++) drv(0, 0, '0, '0, 1, a, 0);
    for (int i = 0; i < 400; i++) begin
      logic [15:0] bm;
      int sel;
      sel = $urandom_range(0, 3);
      bm = sel == 0 ? 16'h0 : sel == 1 ? 16'hFFFF : 16'($urandom);
      if (i == 200) rst_n = 1'b0;
      if (i == 202) rst_n = 1'b1;
      drv($urandom_range(0, 1), $urandom_range(0, 15), {$urandom, $urandom, $urandom, $urandom}, bm,
          $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 49) == 0);
    end
    repeat (20) idle();
    for (int a = 0; a < 16; a++) drv(0, 0, '0, '0, 1, a, 0);
    repeat (4) idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/param_sram_bytemask.md
Name: param_sram_bytemask

Overview:
- Parametrised successor of the team's fixed 16x128b proposal SRAM model.
- Generalises word width, lane count and depth, and adds:
  - a read enable with a read-valid strobe,
  - selectable read latency,
  - read-during-write bypass,
  - an FSM-driven clear engine that zeroes the array after reset or on request.
- Used as the generic on-chip buffer model for the proposal and graph datapaths in simulation.

Parameters:
- BW, 8, bits per byte lane
- Q, 16, lanes per word; word width is BW*Q
- DEPTH, 16, number of words (1..2^ADDR_SPACE)
- ADDR_SPACE, 4, address width
- RD_LAT, 1, read latency in cycles; legal values 1 or 2
- BYPASS, 1, 1 = same-cycle same-address read returns newly written data; 0 = returns old data

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- wsb  input  1  write enable, active low
- wdata  input  BW*Q  write data
- bytemask  input  Q  per-lane mask; 1 = keep old lane, 0 = write lane
- waddr  input  ADDR_SPACE  write address
- rsb  input  1  read enable, active low
- raddr  input  ADDR_SPACE  read address
- clr_start  input  1  single-cycle pulse; start full-array clear
- rdata  output  BW*Q  read data
- rvalid  output  1  rdata valid strobe, one cycle per accepted read
- busy  output  1  high while the clear engine runs

Behaviour:
- Reset (rst_n low, async):
  - rdata=0, rvalid=0, busy=1.
  - FSM forced to CLEAR with clear counter 0.
  - Array contents are not reset directly; the clear engine zeroes them.
- FSM states: CLEAR and IDLE.
  - CLEAR: each cycle, write all-zero to mem[cnt] and increment cnt.
  - CLEAR -> IDLE after writing cnt=DEPTH-1. busy drops in the cycle after the last clear write.
  - Post-reset clear therefore takes exactly DEPTH cycles.
  - IDLE -> CLEAR on clr_start=1 (cnt reset to 0, busy=1 next cycle).
  - clr_start while busy is ignored; the clear does not restart.
- During busy:
  - User writes (wsb=0) are dropped.
  - User reads (rsb=0) are dropped; no rvalid is generated.
  - A read accepted before busy rose still completes normally through the pipeline.
- Write (IDLE, wsb=0):
  - Per lane i: mem[waddr] lane i = bytemask[i] ? old lane : wdata lane i.
  - bytemask all ones = no-op write.
  - If clr_start and wsb=0 arrive in the same IDLE cycle, the clear wins and the write is dropped.
- Read (IDLE, rsb=0):
  - RD_LAT=1: rdata and rvalid update at the next rising edge.
  - RD_LAT=2: one additional output register stage; rvalid is delayed identically.
  - Reads are fully pipelined; back-to-back reads give back-to-back rvalid.
  - When no read completes, rdata holds its last value and rvalid=0.
- Collision (same cycle, rsb=0, wsb=0, raddr==waddr, IDLE):
  - BYPASS=1: returns the merged value (masked lanes old, unmasked lanes new).
  - BYPASS=0: returns the pre-write value.
  - The array is updated in both cases.
- Out-of-range address (>= DEPTH):
  - Write is ignored.
  - Read returns all-zero with rvalid=1.
- Backdoor task load_param(index, data): zero-time direct array write for bench preload. Legal only while busy=0.
- Reset mid-clear or mid-read: pipeline is flushed (rvalid=0) and the clear restarts from 0.

Test Plan:
- Release rst_n, hold wsb=rsb=1 -> busy=1 for exactly DEPTH (16) cycles, then 0. A subsequent read of every address returns 0 with rvalid high one cycle after each request (RD_LAT=1).
- Write 0x0F0E..00 to addr 3 with bytemask=0x0000, then write 0xFF..FF to addr 3 with bytemask=0xFF00 -> read addr 3 returns lanes 15..8 = 0x0F..08 and lanes 7..0 = 0xFF.
- BYPASS=1: addr 5 holds 0xAA.., same-cycle write 0x55.. (mask 0) and read of addr 5 -> rdata=0x55..; with BYPASS=0 -> 0xAA..; re-read returns 0x55.. in both configurations.
- RD_LAT=2: issue reads to addrs 0,1,2 on consecutive cycles -> rvalid high on cycles +2,+3,+4 with matching data; rdata holds the addr-2 data afterwards.
- From IDLE with data preloaded via load_param, pulse clr_start together with wsb=0 to addr 7, plus a second clr_start 4 cycles later -> write dropped, busy lasts exactly DEPTH cycles (no restart), all reads return 0 afterwards. A read issued during busy produces no rvalid.
- DEPTH=12: write to addr 13 then read addr 13 -> rdata=0, rvalid=1; addrs 0..11 unaffected.
